adc_tone_emulator: RTL and testbench
====================================

// Module: adc_tone_emulator
// PURPOSE
// Synthesizable, parametrised emulator of the serial ADC on the waterfall badge.
// It answers the ADC reader's adc_cs/adc_clk with a NUM_TONES-tone synthetic signal
// and supports square, sawtooth, triangle and DC modes, so the SDFT/waterfall chain
// can be self-tested on the board or in simulation without the real ADC.
// It sits between the top-level ADC reader pins and a mux that selects the real adc_sd.
// PARAMETERS
// SAMPLE_WIDTH  12  bits per conversion, shifted MSB first
// LEAD_ZEROS    3   zero bits clocked out before the sample MSB (null/settle bits)
// NUM_TONES     2   number of summed tones; power of two, 1..8
// PHASE_WIDTH   16  phase accumulator width per tone; must be >= SAMPLE_WIDTH+1
// PORTS
// clk        in   1                       system clock (20 MHz on the badge)
// reset_n    in   1                       synchronous, active-low reset
// enable     in   1                       1: phases advance once per conversion; 0: phases frozen
// mode       in   2                       0 square, 1 sawtooth, 2 triangle, 3 DC midscale
// tone_inc   in   NUM_TONES*PHASE_WIDTH   per-tone phase increment per conversion; tone0 in LSBs
// adc_cs     in   1                       chip select from the reader, active low, async to clk
// adc_clk    in   1                       serial clock from the reader, async to clk
// adc_sd     out  1                       serial data to the reader
// sample     out  SAMPLE_WIDTH            value latched for the current/last conversion
// done       out  1                       one-clk pulse after the last data bit is presented
// BEHAVIOUR
// - Reset (reset_n=0 at a clk edge): all phases=0, state IDLE, adc_sd=0, sample=0, done=0.
// - adc_cs and adc_clk each pass through 2 sync flops plus 1 edge-detect flop. adc_sd changes
//   3 clk after an adc_clk falling edge. Requires an adc_clk half period >= 4 clk.
// - Per-tone wave w_i (SAMPLE_WIDTH bits, from phase p_i):
//   square: p_i MSB ? all ones : 0
//   saw:    p_i[PHASE_WIDTH-1 -: SAMPLE_WIDTH]
//   tri:    p_i MSB ? ~p_i[PHASE_WIDTH-2 -: SAMPLE_WIDTH] : p_i[PHASE_WIDTH-2 -: SAMPLE_WIDTH]
//   DC:     1 << (SAMPLE_WIDTH-1)
// - Composite = sum of (w_i >> log2(NUM_TONES)). It cannot overflow SAMPLE_WIDTH, so there is no saturation.
// - States IDLE -> LEAD -> DATA -> TRAIL -> IDLE.
//   IDLE: adc_sd=0. On a synced cs falling edge: sample <= composite from the current phases.
//     If enable=1, every p_i <= p_i + inc_i, wrapping modulo 2^PHASE_WIDTH.
//     Bit counter=0. Go to LEAD, or to DATA if LEAD_ZEROS=0.
//   LEAD: on each adc_clk falling edge, present 0 and count. After LEAD_ZEROS bits, go to DATA.
//   DATA: on each adc_clk falling edge, present sample[SAMPLE_WIDTH-1-k] for k=0..SAMPLE_WIDTH-1.
//     The falling edge after the LSB: adc_sd=0, done=1 for one clk, go to TRAIL.
//   TRAIL: adc_sd=0, extra adc_clk edges ignored. Synced cs rising edge -> IDLE.
// - The MSB is driven on the falling edge after the leading zeros (reader samples on rising edges).
// - A cs rising edge in LEAD or DATA aborts: IDLE, adc_sd=0, no done. Phases stay advanced.
// - A cs falling edge outside IDLE is ignored. Simultaneous cs-rise and adc_clk-fall: cs wins.
// - Reset mid-frame takes precedence over everything: outputs return to reset values next clk.
// - enable and tone_inc are sampled only on the cs falling edge; mid-frame changes have no effect.
// TESTING
// 1 Defaults, square, inc0=0x8000, inc1=0, enable=1, 3 frames -> sample 0x000, 0x7FF, 0x000.
//   Each adc_sd frame is 000 followed by the 12 sample bits, MSB first.
// 2 mode=3 DC, any increments -> every frame shifts 0x800 (0b000_1000_0000_0000); done once per frame.
// 3 Sawtooth, inc0=0x1000, inc1=0x1000, 17 frames -> sample steps 0x000, 0x100, ... 0xF00, then wraps to 0x000.
// 4 cs raised after 6 adc_clk falls -> adc_sd=0, no done. Next frame shows the phase already advanced.
// 5 enable=0 for 3 frames, sawtooth -> identical samples. Reset_n=0 mid-DATA -> adc_sd=0, sample=0.
// 6 Triangle, NUM_TONES=1, inc=0x0800 -> sample rises 0x000..0xF00 by 0x100, then falls 0xFFF..0x0FF.

Source files
------------

// File: rtl/adc_tone_emulator.sv
// adc_tone_emulator: stands in for the badge's serial ADC. It answers the
// reader's adc_cs/adc_clk with a NUM_TONES-tone synthetic waveform (square,
// sawtooth, triangle or DC midscale) so the SDFT/waterfall chain can run
// without the real converter.
//
// Serial protocol: the reader drops adc_cs to start a conversion, then
// toggles adc_clk. This block presents a new bit after every adc_clk falling
// edge (LEAD_ZEROS zeros, then the sample MSB first) and the reader samples
// on rising edges. Raising adc_cs ends or aborts the frame. Both inputs are
// asynchronous to clk, so adc_clk half periods must be at least 4 clk.
module adc_tone_emulator #(
    parameter int SAMPLE_WIDTH = 12,
    parameter int LEAD_ZEROS   = 3,
    parameter int NUM_TONES    = 2,
    parameter int PHASE_WIDTH  = 16
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             enable,
    input  logic [1:0]                       mode,
    input  logic [NUM_TONES*PHASE_WIDTH-1:0] tone_inc,
    input  logic                             adc_cs,
    input  logic                             adc_clk,
    output logic                             adc_sd,
    output logic [SAMPLE_WIDTH-1:0]          sample,
    output logic                             done,
    output logic [1:0]                       state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEAD  = 2'd1,
        DATA  = 2'd2,
        TRAIL = 2'd3
    } state_t;

    localparam int SHIFT = $clog2(NUM_TONES);
    localparam int CNT_W = $clog2(SAMPLE_WIDTH + LEAD_ZEROS + 1);
    localparam logic [CNT_W-1:0] LEAD_LAST = CNT_W'((LEAD_ZEROS > 0) ? LEAD_ZEROS - 1 : 0);
    localparam logic [CNT_W-1:0] DATA_END  = CNT_W'(SAMPLE_WIDTH);
    localparam logic [SAMPLE_WIDTH-1:0] MIDSCALE = SAMPLE_WIDTH'(1) << (SAMPLE_WIDTH - 1);

    state_t                  state;
    logic [CNT_W-1:0]        bit_cnt;
    logic [SAMPLE_WIDTH-1:0] shreg;
    logic [PHASE_WIDTH-1:0]  phase [NUM_TONES];

    // [0],[1] are the synchroniser stages, [2] holds the previous synced value
    logic [2:0] cs_pipe;
    logic [2:0] clk_pipe;
    logic       cs_fall;
    logic       cs_rise;
    logic       clk_fall;

    logic [SAMPLE_WIDTH-1:0] wave;
    logic [SAMPLE_WIDTH-1:0] composite;

    assign cs_fall   = cs_pipe[2] & ~cs_pipe[1];
    assign cs_rise   = ~cs_pipe[2] & cs_pipe[1];
    assign clk_fall  = clk_pipe[2] & ~clk_pipe[1];
    assign state_dbg = state;

    // Synchronise the reader's pins into clk and keep one stage for edge detection
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cs_pipe  <= 3'b111;
            clk_pipe <= 3'b111;
        end else begin
            cs_pipe  <= {cs_pipe[1:0], adc_cs};
            clk_pipe <= {clk_pipe[1:0], adc_clk};
        end
    end

    // Build the composite: each tone pre-scaled by 1/NUM_TONES, so the sum fits
    always_comb begin
        wave      = '0;
        composite = '0;
        for (int i = 0; i < NUM_TONES; i++) begin
            case (mode)
                2'd0:    wave = {SAMPLE_WIDTH{phase[i][PHASE_WIDTH-1]}};
                2'd1:    wave = phase[i][PHASE_WIDTH-1 -: SAMPLE_WIDTH];
                2'd2:    wave = phase[i][PHASE_WIDTH-1] ? ~phase[i][PHASE_WIDTH-2 -: SAMPLE_WIDTH]
                                                        :  phase[i][PHASE_WIDTH-2 -: SAMPLE_WIDTH];
                default: wave = MIDSCALE;
            endcase
            composite = composite + (wave >> SHIFT);
        end
    end

    // Frame FSM: latch and advance on cs fall, shift on adc_clk falls, abort on cs rise
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            adc_sd  <= 1'b0;
            sample  <= '0;
            done    <= 1'b0;
            for (int i = 0; i < NUM_TONES; i++) begin
                phase[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    adc_sd <= 1'b0;
                    if (cs_fall) begin
                        sample  <= composite;
                        shreg   <= composite;
                        bit_cnt <= '0;
                        if (enable) begin
                            for (int i = 0; i < NUM_TONES; i++) begin
                                phase[i] <= phase[i] + tone_inc[i*PHASE_WIDTH +: PHASE_WIDTH];
                            end
                        end
                        if (LEAD_ZEROS == 0) begin
                            state <= DATA;
                        end else begin
                            state <= LEAD;
                        end
                    end
                end
                LEAD: begin
                    if (cs_rise) begin
                        adc_sd <= 1'b0;
                        state  <= IDLE;
                    end else if (clk_fall) begin
                        adc_sd <= 1'b0;
                        if (bit_cnt == LEAD_LAST) begin
                            bit_cnt <= '0;
                            state   <= DATA;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (cs_rise) begin
                        adc_sd <= 1'b0;
                        state  <= IDLE;
                    end else if (clk_fall) begin
                        if (bit_cnt == DATA_END) begin
                            // falling edge after the LSB closes the frame
                            adc_sd <= 1'b0;
                            done   <= 1'b1;
                            state  <= TRAIL;
                        end else begin
                            adc_sd  <= shreg[SAMPLE_WIDTH-1];
                            shreg   <= {shreg[SAMPLE_WIDTH-2:0], 1'b0};
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    adc_sd <= 1'b0;
                    if (cs_rise) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_tone_emulator.sv
// Directed bench for adc_tone_emulator: a two-tone instance covers square,
// DC, sawtooth, abort, enable and mid-frame reset; a one-tone instance on the
// same serial pins covers the triangle sweep.
module tb_adc_tone_emulator;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        reset_n2;
    logic        enable;
    logic [1:0]  mode;
    logic [31:0] tone_inc;
    logic        adc_cs;
    logic        adc_clk;
    logic        adc_sd;
    logic [11:0] sample;
    logic        done;
    logic [1:0]  state_dbg;
    logic        adc_sd2;
    logic [11:0] sample2;
    logic        done2;
    logic [1:0]  state_dbg2;

    int n_checks  = 0;
    int n_fail    = 0;
    int done_cnt  = 0;
    int done2_cnt = 0;

    adc_tone_emulator #(
        .SAMPLE_WIDTH(12), .LEAD_ZEROS(3), .NUM_TONES(2), .PHASE_WIDTH(16)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .mode(mode),
        .tone_inc(tone_inc), .adc_cs(adc_cs), .adc_clk(adc_clk),
        .adc_sd(adc_sd), .sample(sample), .done(done), .state_dbg(state_dbg)
    );

    adc_tone_emulator #(
        .SAMPLE_WIDTH(12), .LEAD_ZEROS(3), .NUM_TONES(1), .PHASE_WIDTH(16)
    ) dut_tri (
        .clk(clk), .reset_n(reset_n2), .enable(1'b1), .mode(mode),
        .tone_inc(16'h0800), .adc_cs(adc_cs), .adc_clk(adc_clk),
        .adc_sd(adc_sd2), .sample(sample2), .done(done2), .state_dbg(state_dbg2)
    );

    // clock
    always #5 clk = ~clk;

    // done pulse counters, sampled mid-cycle
    always @(negedge clk) begin
        if (done)  done_cnt++;
        if (done2) done2_cnt++;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drop cs and give n_falls adc_clk cycles (half period 5 clk); bits are
    // captured on each rising edge, most recent bit in [0]. cs is left low.
    task automatic run_frame(input int n_falls, output logic [14:0] bits1,
                             output logic [14:0] bits2);
        bits1  = '0;
        bits2  = '0;
        adc_cs = 1'b0;
        wait_clk(6);
        for (int f = 0; f < n_falls; f++) begin
            adc_clk = 1'b0;
            wait_clk(5);
            adc_clk = 1'b1;
            if (f < 15) begin
                bits1 = {bits1[13:0], adc_sd};
                bits2 = {bits2[13:0], adc_sd2};
            end
            wait_clk(5);
        end
    endtask

    task automatic end_frame();
        adc_cs = 1'b1;
        wait_clk(6);
    endtask

    // Full 16-fall frame on the two-tone instance with sample, bit and done checks
    task automatic frame_check(input string tag, input logic [11:0] exp);
        logic [14:0] b1;
        logic [14:0] b2;
        int          d0;
        d0 = done_cnt;
        run_frame(16, b1, b2);
        end_frame();
        check($sformatf("%s sample", tag), 32'(sample), 32'(exp));
        check($sformatf("%s bits", tag), 32'(b1), 32'({3'b000, exp}));
        check($sformatf("%s done", tag), 32'(done_cnt - d0), 32'd1);
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        wait_clk(2);
        reset_n = 1'b1;
        wait_clk(2);
    endtask

    initial begin
        logic [14:0] b1;
        logic [14:0] b2;
        logic [11:0] e;
        int          d0;

        reset_n  = 1'b0;
        reset_n2 = 1'b0;
        enable   = 1'b1;
        mode     = 2'd0;
        tone_inc = 32'h0;
        adc_cs   = 1'b1;
        adc_clk  = 1'b1;
        wait_clk(4);

        // reset state
        check("reset adc_sd", 32'(adc_sd), 32'd0);
        check("reset sample", 32'(sample), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset state", 32'(state_dbg), 32'd0);
        reset_n = 1'b1;
        wait_clk(2);

        // square, tone0 flips every frame, tone1 idle
        mode     = 2'd0;
        tone_inc = {16'h0000, 16'h8000};
        frame_check("sq0", 12'h000);
        frame_check("sq1", 12'h7FF);
        frame_check("sq2", 12'h000);

        // DC midscale regardless of increments
        mode     = 2'd3;
        tone_inc = {16'h1234, 16'h0567};
        frame_check("dc0", 12'h800);
        frame_check("dc1", 12'h800);

        // sawtooth, both tones step 0x1000: sample steps 0x100 and wraps after 16
        pulse_reset();
        mode     = 2'd1;
        tone_inc = {16'h1000, 16'h1000};
        for (int k = 0; k < 17; k++) begin
            e = 12'((k % 16) * 256);
            frame_check($sformatf("saw%0d", k), e);
        end

        // abort mid-DATA, phases stay advanced
        pulse_reset();
        tone_inc = {16'h4000, 16'h4000};
        frame_check("abA", 12'h000);
        d0 = done_cnt;
        run_frame(5, b1, b2);
        check("ab sd before", 32'(b1[0]), 32'd1);
        check("ab sample", 32'(sample), 32'h400);
        end_frame();
        check("ab sd after", 32'(adc_sd), 32'd0);
        check("ab state", 32'(state_dbg), 32'd0);
        check("ab no done", 32'(done_cnt - d0), 32'd0);
        frame_check("abC", 12'h800);

        // enable low freezes phases at 0xC000
        enable = 1'b0;
        frame_check("en0", 12'hC00);
        frame_check("en1", 12'hC00);
        frame_check("en2", 12'hC00);

        // reset in the middle of DATA
        d0 = done_cnt;
        run_frame(4, b1, b2);
        check("rst sd before", 32'(b1[0]), 32'd1);
        reset_n = 1'b0;
        wait_clk(1);
        check("rst adc_sd", 32'(adc_sd), 32'd0);
        check("rst sample", 32'(sample), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst state", 32'(state_dbg), 32'd0);
        reset_n = 1'b1;
        end_frame();
        check("rst no done", 32'(done_cnt - d0), 32'd0);
        enable = 1'b1;
        frame_check("post rst", 12'h000);

        // triangle on the single-tone instance, inc 0x0800
        reset_n2 = 1'b1;
        mode     = 2'd2;
        wait_clk(2);
        for (int k = 0; k < 32; k++) begin
            e = (k < 16) ? 12'(k * 256) : 12'(4095 - (k - 16) * 256);
            d0 = done2_cnt;
            run_frame(16, b1, b2);
            end_frame();
            check($sformatf("tri%0d sample", k), 32'(sample2), 32'(e));
            check($sformatf("tri%0d bits", k), 32'(b2), 32'({3'b000, e}));
            check($sformatf("tri%0d done", k), 32'(done2_cnt - d0), 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
